// File: rtl/kernel_weight_buffer_pkg.sv
// Shared types and helpers for the double-buffered kernel weight store.
package kernel_weight_buffer_pkg;

    typedef enum logic {FILL, LOADED} fill_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/weight_stream_packer.sv
// Word counter and shadow shift register that unpacks the weight stream.
module weight_stream_packer
    import kernel_weight_buffer_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int TOTAL_W     = 200
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   clear,
    input  logic                   accept,
    input  logic [INPUT_WIDTH-1:0] wr_data,
    output logic [TOTAL_W-1:0]     shadow,
    output logic                   set_done
);

    localparam int NWORDS = ceil_div(TOTAL_W, INPUT_WIDTH);
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int TAIL_W = TOTAL_W - (NWORDS - 1) * INPUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    logic [CNT_W-1:0] cnt;

    assign set_done = accept && (cnt == LAST);

    // Shifting in from the bottom lands word 0 in the MSBs once the set is
    // complete; only the used head of the last word is shifted in.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt    <= '0;
            shadow <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            if (cnt == LAST) begin
                cnt    <= '0;
                shadow <= TOTAL_W'({shadow, wr_data[INPUT_WIDTH-1 -: TAIL_W]});
            end else begin
                cnt    <= cnt + 1'b1;
                shadow <= TOTAL_W'({shadow, wr_data});
            end
        end
    end

endmodule

// File: rtl/kernel_weight_buffer.sv
// Double-buffered kernel weight store: shadow fill, active bank, promotion.
module kernel_weight_buffer
    import kernel_weight_buffer_pkg::*;
#(
    parameter int INPUT_WIDTH  = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int KERNEL_SIZE  = 5,
    parameter bit AUTO_PROMOTE = 1'b1
) (
    input  logic                                         CLK,
    input  logic                                         RESETN,
    input  logic                                         WR_EN,
    input  logic                                         WR_VALID,
    input  logic [INPUT_WIDTH-1:0]                       WR_DATA,
    output logic                                         WR_READY,
    input  logic                                         CLEAR,
    input  logic                                         SWAP,
    output logic                                         FULL,
    output logic                                         RD_VALID,
    output logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] RD_DATA
);

    localparam int ROW_W   = KERNEL_SIZE * WEIGHT_WIDTH;
    localparam int TOTAL_W = KERNEL_SIZE * ROW_W;

    fill_state_t          state;
    logic                 accept;
    logic                 set_done;
    logic                 promote;
    logic [TOTAL_W-1:0]   shadow;
    logic [TOTAL_W-1:0]   shadow_rows;

    assign accept  = WR_EN && WR_VALID && WR_READY && !CLEAR;
    assign promote = (state == LOADED) && !CLEAR
                   && (SWAP || (AUTO_PROMOTE && !RD_VALID));

    weight_stream_packer #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .TOTAL_W     (TOTAL_W)
    ) u_packer (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .clear    (CLEAR),
        .accept   (accept),
        .wr_data  (WR_DATA),
        .shadow   (shadow),
        .set_done (set_done)
    );

    // Stream order puts row 0 in the MSBs; the read bank wants it in the LSBs.
    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
        assign shadow_rows[r*ROW_W +: ROW_W] = shadow[TOTAL_W-1-r*ROW_W -: ROW_W];
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= FILL;
            WR_READY <= 1'b1;
            FULL     <= 1'b0;
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
        end else if (CLEAR) begin
            state    <= FILL;
            WR_READY <= 1'b1;
            FULL     <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (set_done) begin
                        state    <= LOADED;
                        WR_READY <= 1'b0;
                        FULL     <= !(AUTO_PROMOTE && !RD_VALID);
                    end
                end
                LOADED: begin
                    if (promote) begin
                        state    <= FILL;
                        WR_READY <= 1'b1;
                        FULL     <= 1'b0;
                        RD_VALID <= 1'b1;
                        RD_DATA  <= shadow_rows;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_weight_buffer.sv
// Self-checking bench: word-queue model for defaults plus small parameter sweep.
module tb_kernel_weight_buffer;

    logic         CLK = 1'b0;
    logic         RESETN;
    logic         WR_EN, WR_VALID, CLEAR, SWAP;
    logic [31:0]  WR_DATA;
    logic         WR_READY, FULL, RD_VALID;
    logic [199:0] RD_DATA;

    logic         a_en, a_clr, a_swap, a_ready, a_full, a_rdv;
    logic [63:0]  a_data;
    logic [71:0]  a_rd;

    logic         b_en, b_clr, b_swap, b_ready, b_full, b_rdv;
    logic [31:0]  b_data;
    logic [15:0]  b_rd;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    always #5 CLK = ~CLK;

    kernel_weight_buffer u_dut (
        .CLK(CLK), .RESETN(RESETN), .WR_EN(WR_EN), .WR_VALID(WR_VALID),
        .WR_DATA(WR_DATA), .WR_READY(WR_READY), .CLEAR(CLEAR), .SWAP(SWAP),
        .FULL(FULL), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA)
    );

    kernel_weight_buffer #(
        .INPUT_WIDTH(64), .WEIGHT_WIDTH(8), .KERNEL_SIZE(3)
    ) u_k3 (
        .CLK(CLK), .RESETN(RESETN), .WR_EN(a_en), .WR_VALID(a_en),
        .WR_DATA(a_data), .WR_READY(a_ready), .CLEAR(a_clr), .SWAP(a_swap),
        .FULL(a_full), .RD_VALID(a_rdv), .RD_DATA(a_rd)
    );

    kernel_weight_buffer #(
        .INPUT_WIDTH(32), .WEIGHT_WIDTH(16), .KERNEL_SIZE(1)
    ) u_k1 (
        .CLK(CLK), .RESETN(RESETN), .WR_EN(b_en), .WR_VALID(b_en),
        .WR_DATA(b_data), .WR_READY(b_ready), .CLEAR(b_clr), .SWAP(b_swap),
        .FULL(b_full), .RD_VALID(b_rdv), .RD_DATA(b_rd)
    );

    task automatic chk(input string nm, input logic [199:0] act,
                       input logic [199:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Weight k sits at stream bit offset 8k from the top of the word sequence;
    // row r, column c lands at RD_DATA[r*40 + (4-c)*8 +: 8].
    function automatic logic [199:0] pack_rows(input logic [31:0] w[$]);
        logic [223:0] cat;
        logic [199:0] r;
        cat = '0;
        r   = '0;
        for (int n = 0; n < w.size(); n++) cat[223-32*n -: 32] = w[n];
        for (int k = 0; k < 25; k++)
            r[(k/5)*40 + (4-k%5)*8 +: 8] = cat[223-8*k -: 8];
        return r;
    endfunction

    function automatic logic [71:0] exp_k3(input logic [63:0] w0,
                                           input logic [63:0] w1);
        logic [127:0] cat;
        logic [71:0]  r;
        cat = {w0, w1};
        r   = '0;
        for (int k = 0; k < 9; k++)
            r[(k/3)*24 + (2-k%3)*8 +: 8] = cat[127-8*k -: 8];
        return r;
    endfunction

    logic [31:0]  m_words[$];
    bit           m_loaded, m_full, m_rdv;
    logic [199:0] m_rd;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_words.delete();
            m_loaded = 0;
            m_full   = 0;
            m_rdv    = 0;
            m_rd     = '0;
        end else if (CLEAR) begin
            m_words.delete();
            m_loaded = 0;
            m_full   = 0;
        end else if (m_loaded) begin
            if (SWAP || !m_rdv) begin
                m_rd     = pack_rows(m_words);
                m_rdv    = 1;
                m_loaded = 0;
                m_full   = 0;
                m_words.delete();
            end
        end else if (WR_EN && WR_VALID) begin
            m_words.push_back(WR_DATA);
            if (m_words.size() == 7) begin
                m_loaded = 1;
                m_full   = m_rdv;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("rd_data", RD_DATA, m_rd);
            chk("rd_valid", 200'(RD_VALID), 200'(m_rdv));
            chk("full", 200'(FULL), 200'(m_full));
            chk("wr_ready", 200'(WR_READY), 200'(!m_loaded));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WR_EN    = 0;
        WR_VALID = 0;
        SWAP     = 0;
        CLEAR    = 0;
    endtask

    task automatic send(input logic [31:0] d);
        WR_EN    = 1;
        WR_VALID = 1;
        WR_DATA  = d;
        step();
    endtask

    // Weight k = base + inc*k; padding bytes past weight 24 carry 0xEE.
    task automatic send_set(input logic [7:0] base, input logic [7:0] inc,
                            input bit swap_last);
        for (int n = 0; n < 7; n++) begin
            logic [31:0] w;
            for (int b = 0; b < 4; b++) begin
                int k = 4 * n + b;
                w[31-8*b -: 8] = (k < 25) ? base + inc * 8'(k) : 8'hEE;
            end
            SWAP = swap_last && (n == 6);
            send(w);
        end
        idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdv"}, 200'(RD_VALID), 200'd0);
        chk({tag, "_full"}, 200'(FULL), 200'd0);
        chk({tag, "_ready"}, 200'(WR_READY), 200'd1);
        chk({tag, "_rd"}, RD_DATA, 200'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] x0, x1, y0, y1;
        logic [31:0] z0, z1;
        bit          got;

        RESETN = 0;
        idle();
        WR_DATA = '0;
        a_en = 0; a_clr = 0; a_swap = 0; a_data = '0;
        b_en = 0; b_clr = 0; b_swap = 0; b_data = '0;
        step();
        step();
        chk_reset_vals("por");
        RESETN = 1;
        chk_en = 1;
        step();

        // First set with no active data: auto-promotes, FULL never rises.
        send_set(8'h00, 8'h01, 0);
        chk("t1_rdv_1cyc", 200'(RD_VALID), 200'd0);
        chk("t1_full_1cyc", 200'(FULL), 200'd0);
        step();
        chk("t1_rdv_2cyc", 200'(RD_VALID), 200'd1);
        chk("t1_full", 200'(FULL), 200'd0);
        chk("t1_row0", 200'(RD_DATA[39:0]), 200'h0001020304);
        chk("t1_row4", 200'(RD_DATA[199:160]), 200'h1415161718);

        // Second set waits in the shadow until SWAP.
        send_set(8'hA0, 8'h01, 0);
        step();
        chk("t2_full", 200'(FULL), 200'd1);
        chk("t2_ready", 200'(WR_READY), 200'd0);
        chk("t2_row0_hold", 200'(RD_DATA[39:0]), 200'h0001020304);
        SWAP = 1;
        step();
        SWAP = 0;
        chk("t2_row0_swap", 200'(RD_DATA[39:0]), 200'hA0A1A2A3A4);
        chk("t2_full_clr", 200'(FULL), 200'd0);
        chk("t2_ready_set", 200'(WR_READY), 200'd1);

        // Partial fill discarded by CLEAR; the word beside CLEAR is dropped.
        send(32'h12345678);
        send(32'h12345678);
        send(32'h12345678);
        CLEAR = 1;
        send(32'h9ABCDEF0);
        idle();
        send_set(8'h55, 8'h00, 0);
        step();
        chk("t3_active_kept", 200'(RD_DATA[39:0]), 200'hA0A1A2A3A4);
        chk("t3_full", 200'(FULL), 200'd1);
        SWAP = 1;
        step();
        SWAP = 0;
        for (int r = 0; r < 5; r++)
            chk("t3_row55", 200'(RD_DATA[r*40 +: 40]), 200'h5555555555);

        // Randomly gated handshake.
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            WR_EN    = 1'($urandom_range(0, 1));
            WR_VALID = 1'($urandom_range(0, 1));
            WR_DATA  = $urandom;
            step();
            got = m_loaded;
        end
        idle();
        chk("t4_fill_done", 200'(got), 200'd1);
        step();
        SWAP = 1;
        step();
        SWAP = 0;
        step();

        // SWAP coinciding with the last accept is not queued.
        send_set(8'h30, 8'h01, 1);
        step();
        chk("t5_swap_ignored_full", 200'(FULL), 200'd1);
        SWAP = 1;
        step();
        SWAP = 0;
        chk("t5_row0", 200'(RD_DATA[39:0]), 200'h3031323334);

        // Asynchronous reset mid-fill.
        send(32'h01020304);
        send(32'h05060708);
        send(32'h090A0B0C);
        idle();
        #1 RESETN = 0;
        #1 chk_reset_vals("rst_fill");
        step();
        step();
        RESETN = 1;
        step();

        // Asynchronous reset while a set waits in LOADED.
        send_set(8'h10, 8'h01, 0);
        step();
        send_set(8'h20, 8'h01, 0);
        step();
        chk("t6_full_pre", 200'(FULL), 200'd1);
        #1 RESETN = 0;
        #1 chk_reset_vals("rst_loaded");
        step();
        RESETN = 1;
        step();

        // K=3, W=8, I=64: two words per set.
        x0 = {$urandom, $urandom};
        x1 = {$urandom, $urandom};
        a_en = 1; a_data = x0; step();
        a_data = x1; step();
        a_en = 0;
        chk("k3_rdv_1cyc", 200'(a_rdv), 200'd0);
        step();
        chk("k3_rdv", 200'(a_rdv), 200'd1);
        chk("k3_rd1", 200'(a_rd), 200'(exp_k3(x0, x1)));
        chk("k3_full0", 200'(a_full), 200'd0);
        y0 = {$urandom, $urandom};
        y1 = {$urandom, $urandom};
        a_en = 1; a_data = y0; step();
        a_data = y1; a_swap = 1; step();
        a_en = 0; a_swap = 0;
        chk("k3_full1", 200'(a_full), 200'd1);
        chk("k3_rd_hold", 200'(a_rd), 200'(exp_k3(x0, x1)));
        a_swap = 1; step();
        a_swap = 0;
        chk("k3_rd2", 200'(a_rd), 200'(exp_k3(y0, y1)));
        chk("k3_ready", 200'(a_ready), 200'd1);

        // K=1, W=16, I=32: one word per set, low half ignored.
        z0 = $urandom;
        z1 = $urandom;
        b_en = 1; b_data = z0; step();
        b_en = 0;
        step();
        chk("k1_rdv", 200'(b_rdv), 200'd1);
        chk("k1_rd1", 200'(b_rd), 200'(z0[31:16]));
        b_en = 1; b_data = z1; b_swap = 1; step();
        b_en = 0; b_swap = 0;
        chk("k1_full1", 200'(b_full), 200'd1);
        chk("k1_rd_hold", 200'(b_rd), 200'(z0[31:16]));
        b_swap = 1; step();
        b_swap = 0;
        chk("k1_rd2", 200'(b_rd), 200'(z1[31:16]));
        chk("k1_full0", 200'(b_full), 200'd0);

        step();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/kernel_weight_buffer.md
# kernel_weight_buffer

Double-buffered, parametrised kernel weight store for the MLP/conv datapath. It sits between the AXI-stream weight DMA and the convolution MAC array. It unpacks a stream of INPUT_WIDTH-bit words into a KERNEL_SIZE x KERNEL_SIZE array of WEIGHT_WIDTH-bit weights. A complete set is filled into a shadow bank while the MAC array reads the active bank, and the two banks swap on request with no read-side bubble.

## Interface
- INPUT_WIDTH, 32, stream word width (bits); any value >= WEIGHT_WIDTH.
- WEIGHT_WIDTH, 8, width of one weight.
- KERNEL_SIZE, 5, kernel is KERNEL_SIZE x KERNEL_SIZE; >= 1.
- AUTO_PROMOTE, 1, if 1, a completed shadow set is promoted immediately when no active set is valid.
- Derived: ROW_W = KERNEL_SIZE*WEIGHT_WIDTH; TOTAL_W = KERNEL_SIZE*ROW_W; NWORDS = ceil(TOTAL_W/INPUT_WIDTH) (7 at defaults).
- CLK  in  1  clock; all state on rising edge.
- RESETN  in  1  reset; one clock; reset is asynchronous and active-low.
- WR_EN  in  1  write enable.
- WR_VALID  in  1  stream data valid.
- WR_DATA  in  INPUT_WIDTH  stream word.
- WR_READY  out  1  shadow bank accepting words.
- CLEAR  in  1  discard partially/fully filled shadow set.
- SWAP  in  1  request shadow -> active promotion.
- FULL  out  1  shadow holds a complete set awaiting promotion.
- RD_VALID  out  1  active bank holds a valid set.
- RD_DATA  out  KERNEL_SIZE*ROW_W  active bank; row r at RD_DATA[r*ROW_W +: ROW_W]; within a row, column 0 in MSBs.

## Operation
- Accept = WR_EN & WR_VALID & WR_READY. WR_READY = (fill state == FILL).
- Packing: weights in row-major order (r0c0, r0c1, ...), first weight in MSBs of the first word, contiguous across word boundaries. Word n fills shadow bits [TOTAL_W-1-n*INPUT_WIDTH -: INPUT_WIDTH]. Bits beyond TOTAL_W in the last word are ignored.
- Word counter 0..NWORDS-1. It wraps to 0 on the last accepted word, and the fill FSM moves FILL -> LOADED.
- Fill FSM states: FILL, LOADED.
  - FILL -> LOADED: the last word is accepted.
  - LOADED -> FILL: a promotion occurs, or CLEAR.
- Promotion: in LOADED, when SWAP=1, or when AUTO_PROMOTE=1 and RD_VALID=0. Promotion copies shadow to active, sets RD_VALID=1, clears FULL and returns the FSM to FILL.
- SWAP in FILL is ignored; it is not queued.
- CLEAR: counter <= 0, FSM <= FILL, FULL <= 0. Active bank and RD_VALID are unaffected.
- Priority in one cycle: CLEAR > promotion > write. A word presented with CLEAR is dropped.
- The active bank is never modified except by promotion or reset.

## Timing
- Reset values: RD_DATA = 0, RD_VALID = 0, FULL = 0, WR_READY = 1, counter = 0, FSM = FILL.
- Reset mid-fill discards everything.
- FULL rises the cycle after the last accept. WR_READY falls in the same cycle as FULL rises.
- Promotion in cycle t: RD_DATA and RD_VALID update at t+1, and WR_READY = 1 at t+1.
  - A new fill may start at t+1, giving zero-bubble back-to-back sets.
- AUTO_PROMOTE with RD_VALID=0: FULL never rises. RD_VALID rises 2 cycles after the last accept (accept -> LOADED -> promote).
- SWAP and the last accept in the same cycle: SWAP is ignored.
- Minimum set period: NWORDS + 1 cycles.
- WR_READY is a registered function of state only; it has no combinational path from inputs.

## Structure
- Package kernel_weight_buffer_pkg holds:
  - fill_state_t enum {FILL, LOADED};
  - function ceil_div(a, b) for NWORDS.
- Sub-module weight_stream_packer: word counter plus shadow shift/insert logic. Outputs the TOTAL_W vector and a set_done pulse.
- The top level holds the FSM, active bank, promotion and CLEAR logic.

## Test plan
- Defaults; stream weight i = i (i = 0..24), i.e. words 0x00010203, 0x04050607, ..., 0x14151617, 0x18XXXXXX, each with WR_EN = WR_VALID = 1.
  - Required: RD_VALID = 1 at 2 cycles after the last word; row0 = 0x0001020304; row4 = 0x1415161718; FULL stays 0.
- With an active set valid, stream a second set with weights 0xA0 + i, then hold SWAP = 0.
  - Required: FULL = 1 and WR_READY = 0; RD_DATA unchanged.
  - Then pulse SWAP: next cycle row0 = 0xA0A1A2A3A4, FULL = 0, WR_READY = 1.
- Write 3 words, assert CLEAR with a 4th word, then stream a full set of 0x55 weights.
  - Required: all rows 0x5555555555; the active bank is untouched until promotion.
- Toggle WR_VALID and WR_EN randomly (50%) during a fill.
  - Required: only accepted words advance the counter; result matches the packed model.
- Assert RESETN low mid-fill and mid-LOADED.
  - Required: all outputs return to reset values asynchronously; RD_VALID = 0.
- Parameter sweep, checked against a reference packing model with random data:
  - KERNEL_SIZE = 3, WEIGHT_WIDTH = 8, INPUT_WIDTH = 64 (NWORDS = 2);
  - KERNEL_SIZE = 1, WEIGHT_WIDTH = 16, INPUT_WIDTH = 32;
  - SWAP asserted together with the last accept is ignored.
